// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package fetch_pkg;

  // S_FETCH: normal sequential fetch; S_DRAIN: waiting out a wrong-path request
  typedef enum logic {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam int          PC_INC   = 4;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus: hazard/branch controls, instruction-memory port, IF/ID register.
//
// Memory handshake: imem_req is the valid. Once raised it stays high with a
// constant imem_addr until a cycle where imem_ready is also high; that cycle is
// the transfer, and imem_data is valid in that same cycle. Ready may be high in
// the first cycle of a request (zero-wait). Ready without req has no effect.
interface fetch_if #(
  parameter int PC_W = 9
);
  logic            stall;
  logic            pc_sel;
  logic [31:0]     br_pc;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_data;
  logic            ifid_valid;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_inst;

  modport master (
    input  stall, pc_sel, br_pc, imem_ready, imem_data,
    output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst
  );

  modport slave (
    output stall, pc_sel, br_pc, imem_ready, imem_data,
    input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_inst
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {valid, pc, inst} holding buffer for a response accepted while
// IF/ID is frozen. Clear wins over load, load wins over drain.
module fetch_skid_buf #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            drain,
  input  logic [PC_W-1:0] load_pc,
  input  logic [31:0]     load_inst,
  output logic            valid,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     inst
);

  // Entry register: clear/load/drain with async reset to empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues handshaked memory requests,
// applies branch redirects and produces the IF/ID register. Wrong-path
// responses (accepted during or after a redirect) are dropped, and a request
// that is already pending when a redirect lands is drained before the target
// is fetched so the memory protocol is never broken.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_if.master      bus,
  output fetch_state_e dbg_state
);

  fetch_state_e    state_q, state_d;
  logic            start_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redir_q, redir_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;

  logic            skid_valid;
  logic [PC_W-1:0] skid_pc;
  logic [31:0]     skid_inst;
  logic            skid_clear, skid_load, skid_drain;

  logic            req;
  logic            accept;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            unused_br;

  // A full skid means IF/ID has nowhere to put another response, so hold off;
  // in drain the old request must be kept alive regardless.
  assign req    = start_q && (state_q == S_DRAIN || !skid_valid);
  assign accept = req && bus.imem_ready;
  assign target = {bus.br_pc[PC_W-1:2], 2'b00};
  assign pc_inc = pc_q + PC_W'(PC_INC);

  // Upper target bits and byte offset are intentionally ignored
  assign unused_br = ^{bus.br_pc[31:PC_W], bus.br_pc[1:0]};

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .drain     (skid_drain),
    .load_pc   (pc_q),
    .load_inst (bus.imem_data),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  // Next-state and datapath control: redirect > stall > normal
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_d      = redir_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    skid_clear   = 1'b0;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;

    if (start_q) begin
      case (state_q)
        S_DRAIN: begin
          // Old request completes with its data thrown away; newest target wins
          ifid_valid_d = 1'b0;
          if (bus.pc_sel) redir_d = target;
          if (accept) begin
            pc_d    = bus.pc_sel ? target : redir_q;
            state_d = S_FETCH;
          end
        end
        default: begin
          if (bus.pc_sel) begin
            ifid_valid_d = 1'b0;
            skid_clear   = 1'b1;
            if (!req || accept) begin
              pc_d = target;
            end else begin
              redir_d = target;
              state_d = S_DRAIN;
            end
          end else if (bus.stall) begin
            if (accept) begin
              skid_load = 1'b1;
              pc_d      = pc_inc;
            end
          end else begin
            if (accept) pc_d = pc_inc;
            if (skid_valid) begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = skid_pc;
              ifid_inst_d  = skid_inst;
              if (accept) skid_load  = 1'b1;
              else        skid_drain = 1'b1;
            end else if (accept) begin
              ifid_valid_d = 1'b1;
              ifid_pc_d    = pc_q;
              ifid_inst_d  = bus.imem_data;
            end else begin
              ifid_valid_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // State, PC, pending target and IF/ID registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      start_q      <= 1'b0;
      pc_q         <= RESET_PC;
      redir_q      <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
    end else begin
      state_q      <= state_d;
      start_q      <= 1'b1;
      pc_q         <= pc_d;
      redir_q      <= redir_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_inst  = ifid_inst_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, async-reset-in-drain sequence,
// and randomized run against a program-order reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PC_W  = 9;
  localparam int PC_MOD = 1 << PC_W;

  logic         clk = 1'b0;
  logic         reset;
  fetch_state_e dbg_state;

  fetch_if #(.PC_W(PC_W)) bus();

  fetch_unit #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Instruction memory contents: distinct word per address
  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return 32'h5A00_0003 | (32'(a) << 8);
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic [31:0] br, input logic r);
    bus.stall      = s;
    bus.pc_sel     = p;
    bus.br_pc      = br;
    bus.imem_ready = r;
  endtask

  // Advance one edge and land 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(bus.imem_req),   32'd0);
    check({tag, "_addr"},  32'(bus.imem_addr),  32'd0);
    check({tag, "_valid"}, 32'(bus.ifid_valid), 32'd0);
    check({tag, "_pc"},    32'(bus.ifid_pc),    32'd0);
    check({tag, "_inst"},  bus.ifid_inst,       NOP_INST);
    check({tag, "_state"}, 32'(dbg_state),      32'(S_FETCH));
  endtask

  // Directed vectors: inputs for one cycle, request seen in that cycle,
  // IF/ID expected after the edge
  typedef struct {
    logic            stall;
    logic            pc_sel;
    logic [31:0]     br_pc;
    logic            ready;
    logic            exp_req;
    logic [PC_W-1:0] exp_addr;
    logic            exp_v;
    logic [PC_W-1:0] exp_pc;
    logic [31:0]     exp_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int s, input int p, input int br, input int r,
                         input int er, input int ea, input int ev, input int ep,
                         input bit nop);
    vec_t v;
    v.stall    = 1'(s);
    v.pc_sel   = 1'(p);
    v.br_pc    = 32'(br);
    v.ready    = 1'(r);
    v.exp_req  = 1'(er);
    v.exp_addr = PC_W'(ea);
    v.exp_v    = 1'(ev);
    v.exp_pc   = PC_W'(ep);
    v.exp_inst = nop ? NOP_INST : mem_word(PC_W'(ep));
    vecs.push_back(v);
  endtask

  // Random-phase reference model state
  int  exp_pc;
  bit  m_valid;
  int  m_pc;
  int  idle;
  int  deliveries;
  logic            p_req, p_ready, p_stall, p_sel;
  logic [PC_W-1:0] p_addr;
  logic [31:0]     p_br;
  logic            prev_wait;
  logic [PC_W-1:0] prev_addr;

  initial begin
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b0;

    //               s  p  br      r  req addr  v  pc    nop
    add_vec(0, 0, 0,      0, 0, 'h000, 0, 'h000, 1); // start flag sets
    add_vec(0, 0, 0,      1, 1, 'h000, 1, 'h000, 0); // zero-wait fetch
    add_vec(0, 0, 0,      1, 1, 'h004, 1, 'h004, 0);
    add_vec(0, 0, 0,      1, 1, 'h008, 1, 'h008, 0);
    add_vec(0, 1, 'h40,   1, 1, 'h00C, 0, 'h008, 0); // redirect on accept
    add_vec(0, 0, 0,      1, 1, 'h040, 1, 'h040, 0);
    add_vec(0, 0, 0,      1, 1, 'h044, 1, 'h044, 0);
    add_vec(1, 0, 0,      1, 1, 'h048, 1, 'h044, 0); // stall: 0x048 to skid
    add_vec(1, 0, 0,      1, 0, 'h04C, 1, 'h044, 0);
    add_vec(1, 0, 0,      1, 0, 'h04C, 1, 'h044, 0);
    add_vec(0, 0, 0,      1, 0, 'h04C, 1, 'h048, 0); // skid drains into IF/ID
    add_vec(0, 0, 0,      1, 1, 'h04C, 1, 'h04C, 0);
    add_vec(0, 0, 0,      1, 1, 'h050, 1, 'h050, 0);
    add_vec(0, 0, 0,      0, 1, 'h054, 0, 'h050, 0); // wait: bubble
    add_vec(0, 1, 'h80,   0, 1, 'h054, 0, 'h050, 0); // redirect while pending
    add_vec(0, 1, 'h90,   0, 1, 'h054, 0, 'h050, 0); // newer redirect in drain
    add_vec(1, 0, 0,      0, 1, 'h054, 0, 'h050, 0); // stall ignored in drain
    add_vec(0, 0, 0,      1, 1, 'h054, 0, 'h050, 0); // drained, data dropped
    add_vec(0, 0, 0,      1, 1, 'h090, 1, 'h090, 0);
    add_vec(0, 0, 0,      1, 1, 'h094, 1, 'h094, 0);
    add_vec(0, 1, 'h203,  1, 1, 'h098, 0, 'h094, 0); // truncated target 0x000
    add_vec(0, 0, 0,      1, 1, 'h000, 1, 'h000, 0);
    add_vec(0, 1, 'h1F8,  1, 1, 'h004, 0, 'h000, 0);
    add_vec(0, 0, 0,      1, 1, 'h1F8, 1, 'h1F8, 0);
    add_vec(0, 0, 0,      1, 1, 'h1FC, 1, 'h1FC, 0);
    add_vec(0, 0, 0,      1, 1, 'h000, 1, 'h000, 0); // wrapped
    add_vec(1, 1, 'h100,  1, 1, 'h004, 0, 'h000, 0); // redirect beats stall
    add_vec(0, 0, 0,      1, 1, 'h100, 1, 'h100, 0);

    // Reset held for 3 cycles
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].pc_sel, vecs[i].br_pc, vecs[i].ready);
      check($sformatf("vec%0d_req", i),  32'(bus.imem_req),  32'(vecs[i].exp_req));
      check($sformatf("vec%0d_addr", i), 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
      step();
      check($sformatf("vec%0d_valid", i), 32'(bus.ifid_valid), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_pc", i),    32'(bus.ifid_pc),    32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_inst", i),  bus.ifid_inst,       vecs[i].exp_inst);
    end

    // Async reset while draining: no stale target after restart
    drive(1'b0, 1'b1, 32'h1C0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    check("drain_state", 32'(dbg_state), 32'(S_DRAIN));
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    step();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b1);
    check("restart_req0", 32'(bus.imem_req), 32'd0);
    step();
    check("restart_req1", 32'(bus.imem_req), 32'd1);
    check("restart_addr0", 32'(bus.imem_addr), 32'h000);
    step();
    check("restart_ifid0", 32'(bus.ifid_pc), 32'h000);
    check("restart_addr1", 32'(bus.imem_addr), 32'h004);
    step();
    check("restart_ifid1", 32'(bus.ifid_pc), 32'h004);
    check("restart_v1", 32'(bus.ifid_valid), 32'd1);

    // Randomized run: decoded stream must follow program order from the
    // latest redirect target, and memory requests must stay stable until taken
    m_valid = 1'b0;
    m_pc = 0;
    exp_pc = 0;
    idle = 0;
    deliveries = 0;
    prev_wait = 1'b0;
    prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) == 0,
            (c == 0) || ($urandom_range(0, 7) == 0),
            $urandom(),
            $urandom_range(0, 3) != 0);
      if (prev_wait) begin
        check("req_held", 32'(bus.imem_req), 32'd1);
        check("addr_stable", 32'(bus.imem_addr), 32'(prev_addr));
      end
      if (bus.imem_req) check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
      p_req   = bus.imem_req;
      p_addr  = bus.imem_addr;
      p_ready = bus.imem_ready;
      p_stall = bus.stall;
      p_sel   = bus.pc_sel;
      p_br    = bus.br_pc;
      step();
      prev_wait = p_req && !p_ready;
      prev_addr = p_addr;

      if (p_sel) begin
        exp_pc  = (int'(p_br % 32'(PC_MOD)) / 4) * 4;
        m_valid = 1'b0;
        idle    = 0;
        check("rnd_redirect_bubble", 32'(bus.ifid_valid), 32'd0);
      end else if (p_stall) begin
        check("rnd_stall_valid", 32'(bus.ifid_valid), 32'(m_valid));
        if (m_valid) check("rnd_stall_pc", 32'(bus.ifid_pc), 32'(m_pc));
      end else if (bus.ifid_valid) begin
        check("rnd_ifid_pc", 32'(bus.ifid_pc), 32'(exp_pc));
        check("rnd_ifid_inst", bus.ifid_inst, mem_word(PC_W'(exp_pc)));
        m_valid = 1'b1;
        m_pc    = exp_pc;
        exp_pc  = (exp_pc + 4) % PC_MOD;
        idle    = 0;
        deliveries++;
      end else begin
        m_valid = 1'b0;
        idle++;
        if (idle > 64) begin
          checks++;
          errors++;
          $display("FAIL rnd_progress: got %0d idle cycles required at most 64", idle);
          idle = 0;
        end
      end
    end
    check("rnd_deliveries", 32'(deliveries > 300), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
